// File: rtl/toast_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide, WIDTH+2 cycles (1 on zero/overflow fast path).
// No backpressure: new starts are ignored while busy_o is high; flush_i aborts without a done_o pulse.
module toast_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic             sel_rem;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;

  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[WIDTH-1];
    b_neg     = is_signed & divisor_i[WIDTH-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    div_zero  = (divisor_i == '0);
    ovf       = is_signed && (dividend_i == MIN_NEG) && (&divisor_i);
    if (div_zero) fast_res = op_i[1] ? dividend_i : '1;
    else          fast_res = op_i[1] ? '0 : MIN_NEG;
    // rem < divisor always holds, so bit WIDTH of the difference is a reliable sign.
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_mag};
    quo_fix = q_neg ? -quo : quo;
    rem_fix = r_neg ? -rem : rem;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= IDLE;
      sel_rem  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvs_mag  <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            sel_rem <= op_i[1];
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            dvs_mag <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            cnt     <= '0;
            if (div_zero || ovf) begin
              result_o <= fast_res;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            result_o <= sel_rem ? rem_fix : quo_fix;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule
